// File: rtl/lines_cleared_score_ctrl.sv
// lines_cleared_score_ctrl
//
// Keeps the running lines-cleared count for the current game and turns it
// into ASCII decimal characters for the lines-cleared text region. The
// binary count is converted with an iterative double-dabble sequencer, and
// new characters are published only during vertical blanking so the glyph
// renderers never see a mid-frame change.
//
// Ports
//   clk          system clock (single domain)
//   rst_l        asynchronous active-low reset
//   game_start   one-cycle pulse, zeroes the count for a new game
//   clear_valid  one-cycle pulse, clear_count lines were just cleared
//   clear_count  number of lines cleared (0-7)
//   vblank       high while the display is in vertical blanking
//   lines_total  registered binary line count
//   digit_chars  ASCII characters, index 0 is the most significant digit
//   busy         high while a conversion is running or awaiting publish
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | result published, nothing pending
// ST_CONVERT   | double-dabble iterations in progress (CNT_WIDTH cycles)
// ST_WAIT_VBLANK | conversion done, holding result until vblank is high

module lines_cleared_score_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_WIDTH  = 14,
    parameter int MAX_COUNT  = 9999
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             game_start,
    input  logic                             clear_valid,
    input  logic [2:0]                       clear_count,
    input  logic                             vblank,
    output logic [CNT_WIDTH-1:0]             lines_total,
    output logic [0:NUM_DIGITS-1][7:0]       digit_chars,
    output logic                             busy
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int ITER_W = $clog2(CNT_WIDTH + 1);
    localparam logic [ITER_W-1:0]      ITER_LAST = ITER_W'(CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH:0]     MAX_EXT   = (CNT_WIDTH + 1)'(MAX_COUNT);
    localparam logic [0:NUM_DIGITS-1][7:0] DIGITS_RST =
        {{(NUM_DIGITS - 1){8'h20}}, 8'h30};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_WAIT_VBLANK
    } state_t;

    state_t                       state_q,  state_d;
    logic [CNT_WIDTH-1:0]         lines_q,  lines_d;
    logic [CNT_WIDTH-1:0]         shift_q,  shift_d;
    logic [BCD_W-1:0]             bcd_q,    bcd_d;
    logic [ITER_W-1:0]            iter_q,   iter_d;
    logic [0:NUM_DIGITS-1][7:0]   digits_q, digits_d;

    logic [CNT_WIDTH:0]           sum_ext;
    logic                         event_start;
    logic [BCD_W-1:0]             bcd_adj;
    logic [BCD_W-1:0]             bcd_sh;
    logic [CNT_WIDTH-1:0]         shift_sh;
    logic [0:NUM_DIGITS-1][7:0]   chars;
    logic                         blank;
    logic [3:0]                   nib;

    // Count update; the sum is one bit wider so the clamp sees true overflow.
    always_comb begin
        sum_ext     = {1'b0, lines_q} + {{(CNT_WIDTH - 2){1'b0}}, clear_count};
        event_start = game_start | (clear_valid & (clear_count != 3'd0));
        lines_d     = lines_q;
        if (game_start) begin
            lines_d = '0;
        end else if (clear_valid) begin
            lines_d = (sum_ext > MAX_EXT) ? MAX_EXT[CNT_WIDTH-1:0]
                                          : sum_ext[CNT_WIDTH-1:0];
        end
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_sh   = {bcd_adj[BCD_W-2:0], shift_q[CNT_WIDTH-1]};
        shift_sh = {shift_q[CNT_WIDTH-2:0], 1'b0};
    end

    // Character mapping with leading-zero blanking; the last digit always shows.
    always_comb begin
        chars = '0;
        blank = 1'b1;
        nib   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = bcd_q[4*(NUM_DIGITS-1-i) +: 4];
            if ((nib != 4'd0) || (i == NUM_DIGITS - 1)) begin
                blank = 1'b0;
            end
            chars[i] = blank ? 8'h20 : (8'h30 + {4'h0, nib});
        end
    end

    // Next-state logic. An event restarts from any state using the new count,
    // so only the newest value is ever published. iter_q is a down-counter;
    // the iteration where it reads zero is the last one.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        digits_d = digits_q;
        if (event_start) begin
            state_d = ST_CONVERT;
            shift_d = lines_d;
            bcd_d   = '0;
            iter_d  = ITER_LAST;
        end else begin
            case (state_q)
                ST_CONVERT: begin
                    bcd_d   = bcd_sh;
                    shift_d = shift_sh;
                    if (iter_q == '0) begin
                        state_d = ST_WAIT_VBLANK;
                    end else begin
                        iter_d = iter_q - ITER_W'(1);
                    end
                end
                ST_WAIT_VBLANK: begin
                    if (vblank) begin
                        digits_d = chars;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= ST_IDLE;
            lines_q  <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            digits_q <= DIGITS_RST;
        end else begin
            state_q  <= state_d;
            lines_q  <= lines_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            digits_q <= digits_d;
        end
    end

    assign lines_total = lines_q;
    assign digit_chars = digits_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lines_cleared_score_ctrl.sv
module tb_lines_cleared_score_ctrl;

    logic             clk = 1'b0;
    logic             rst_l = 1'b0;
    logic             game_start = 1'b0;
    logic             clear_valid = 1'b0;
    logic [2:0]       clear_count = 3'd0;
    logic             vblank = 1'b1;
    logic [13:0]      lines_total;
    logic [0:3][7:0]  digit_chars;
    logic             busy;

    lines_cleared_score_ctrl dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .game_start (game_start),
        .clear_valid(clear_valid),
        .clear_count(clear_count),
        .vblank     (vblank),
        .lines_total(lines_total),
        .digit_chars(digit_chars),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          model  = 0;
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_dc = '0;
    logic [31:0] mon_exp;

    function automatic logic [31:0] exp_chars(input int n);
        logic [31:0] r;
        int v;
        int p;
        v = n;
        p = 1;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (i == 3 || n >= p) r[8*(3-i) +: 8] = 8'h30 + 8'(v % 10);
            else                  r[8*(3-i) +: 8] = 8'h20;
            v = v / 10;
            p = p * 10;
        end
        return r;
    endfunction

    // Scoreboard monitor: a publish is the busy 1->0 transition; any other
    // change of digit_chars is an error.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL publish_unexpected got %h exp none", digit_chars);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (digit_chars !== mon_exp) begin
                        errors++;
                        $display("FAIL publish_value got %h exp %h", digit_chars, mon_exp);
                    end
                end
            end else if (digit_chars !== prev_dc) begin
                errors++;
                $display("FAIL digit_hold got %h exp %h", digit_chars, prev_dc);
            end
        end
        prev_busy = busy;
        prev_dc   = digit_chars;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic pulse_clear(input int n);
        clear_valid = 1'b1;
        clear_count = n[2:0];
        @(negedge clk);
        clear_valid = 1'b0;
        clear_count = 3'd0;
        model = (model + n > 9999) ? 9999 : model + n;
    endtask

    task automatic pulse_start();
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        model = 0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle_timeout got busy=1 exp busy=0");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (digit_chars !== exp_chars(0) || lines_total !== 14'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got %h/%0d/%b exp %h/0/0", digit_chars, lines_total, busy, exp_chars(0));
        end
        @(negedge clk);
        rst_l = 1'b1;
        mon_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || lines_total !== 14'd0) begin
                errors++;
                $display("FAIL idle_after_reset got busy=%b lines=%0d exp busy=0 lines=0", busy, lines_total);
            end
        end
    endtask

    task automatic test_single_clear();
        bit all_busy;
        pulse_clear(4);
        exp_q.push_back(exp_chars(4));
        checks++;
        if (lines_total !== 14'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_cycle1 got lines=%0d busy=%b exp lines=4 busy=1", lines_total, busy);
        end
        all_busy = 1'b1;
        repeat (14) begin
            @(negedge clk);
            if (busy !== 1'b1) all_busy = 1'b0;
        end
        checks++;
        if (!all_busy) begin
            errors++;
            $display("FAIL single_busy_window got low exp high cycles 2-15");
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || digit_chars !== exp_chars(4)) begin
            errors++;
            $display("FAIL single_publish got %h busy=%b exp %h busy=0", digit_chars, busy, exp_chars(4));
        end
        wait_idle(100);
    endtask

    task automatic test_vblank_gating();
        pulse_start();
        repeat (5) pulse_clear(7);
        pulse_clear(2);
        exp_q.push_back(exp_chars(37));
        wait_idle(100);
        vblank = 1'b0;
        pulse_clear(3);
        exp_q.push_back(exp_chars(40));
        repeat (200) @(negedge clk);
        checks++;
        if (digit_chars !== exp_chars(37) || busy !== 1'b1 || lines_total !== 14'd40) begin
            errors++;
            $display("FAIL gating_hold got %h busy=%b lines=%0d exp %h busy=1 lines=40", digit_chars, busy, lines_total, exp_chars(37));
        end
        vblank = 1'b1;
        @(negedge clk);
        checks++;
        if (digit_chars !== exp_chars(40) || busy !== 1'b0) begin
            errors++;
            $display("FAIL gating_release got %h busy=%b exp %h busy=0", digit_chars, busy, exp_chars(40));
        end
        wait_idle(100);
    endtask

    task automatic test_restart();
        pulse_start();
        exp_q.push_back(exp_chars(0));
        wait_idle(100);
        pulse_clear(1);
        repeat (4) @(negedge clk);
        pulse_clear(2);
        exp_q.push_back(exp_chars(3));
        repeat (14) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || digit_chars !== exp_chars(0)) begin
            errors++;
            $display("FAIL restart_cycle20 got %h busy=%b exp %h busy=1", digit_chars, busy, exp_chars(0));
        end
        @(negedge clk);
        checks++;
        if (digit_chars !== exp_chars(3) || lines_total !== 14'd3) begin
            errors++;
            $display("FAIL restart_cycle21 got %h lines=%0d exp %h lines=3", digit_chars, lines_total, exp_chars(3));
        end
        wait_idle(100);
    endtask

    task automatic test_saturation();
        pulse_start();
        repeat (1428) pulse_clear(7);
        pulse_clear(2);
        checks++;
        if (lines_total !== 14'd9998) begin
            errors++;
            $display("FAIL sat_preload got %0d exp 9998", lines_total);
        end
        pulse_clear(4);
        exp_q.push_back(exp_chars(model));
        wait_idle(100);
        checks++;
        if (lines_total !== 14'd9999 || digit_chars !== exp_chars(9999)) begin
            errors++;
            $display("FAIL sat_clamp got %0d %h exp 9999 %h", lines_total, digit_chars, exp_chars(9999));
        end
        pulse_clear(1);
        exp_q.push_back(exp_chars(model));
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_reconvert got busy=%b exp busy=1", busy);
        end
        wait_idle(100);
        checks++;
        if (lines_total !== 14'd9999 || digit_chars !== exp_chars(9999)) begin
            errors++;
            $display("FAIL sat_hold got %0d %h exp 9999 %h", lines_total, digit_chars, exp_chars(9999));
        end
    endtask

    task automatic test_priority();
        pulse_start();
        repeat (17) pulse_clear(7);
        pulse_clear(1);
        exp_q.push_back(exp_chars(120));
        wait_idle(100);
        checks++;
        if (lines_total !== 14'd120) begin
            errors++;
            $display("FAIL prio_preload got %0d exp 120", lines_total);
        end
        game_start  = 1'b1;
        clear_valid = 1'b1;
        clear_count = 3'd3;
        @(negedge clk);
        game_start  = 1'b0;
        clear_valid = 1'b0;
        clear_count = 3'd0;
        model = 0;
        checks++;
        if (lines_total !== 14'd0) begin
            errors++;
            $display("FAIL prio_lines got %0d exp 0", lines_total);
        end
        exp_q.push_back(exp_chars(0));
        wait_idle(100);
        checks++;
        if (digit_chars !== exp_chars(0)) begin
            errors++;
            $display("FAIL prio_digits got %h exp %h", digit_chars, exp_chars(0));
        end
        pulse_clear(0);
        repeat (5) begin
            checks++;
            if (busy !== 1'b0 || lines_total !== 14'd0) begin
                errors++;
                $display("FAIL zero_clear got busy=%b lines=%0d exp busy=0 lines=0", busy, lines_total);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midconv();
        pulse_clear(5);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        rst_l  = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || lines_total !== 14'd0 || digit_chars !== exp_chars(0)) begin
            errors++;
            $display("FAIL reset_midconv got %h/%0d/%b exp %h/0/0", digit_chars, lines_total, busy, exp_chars(0));
        end
        exp_q.delete();
        model = 0;
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || digit_chars !== exp_chars(0)) begin
            errors++;
            $display("FAIL reset_midconv_after got %h busy=%b exp %h busy=0", digit_chars, busy, exp_chars(0));
        end
    endtask

    initial begin
        test_reset();
        test_single_clear();
        test_vblank_gating();
        test_restart();
        test_saturation();
        test_priority();
        test_reset_midconv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lines_cleared_score_ctrl.md
# lines_cleared_score_ctrl

Tracks the running count of lines cleared in the current game and converts it to ASCII decimal digits for the lines-cleared text region beside the playfield. Converts binary to BCD with an iterative double-dabble sequencer. Publishes new digit characters only during vertical blanking, so the glyph renderers never change mid-frame. It sits between game logic (line-clear events) and the lines-cleared pixel driver (character inputs).

## Interface
- `NUM_DIGITS`, default 4: number of decimal digits displayed.
- `CNT_WIDTH`, default 14: width of the binary line count. It must hold `MAX_COUNT`.
- `MAX_COUNT`, default 9999: saturation value of the count.
- `clk` input, 1 bit: system clock. One clock domain.
- `rst_l` input, 1 bit: reset, asynchronous and active-low.
- `game_start` input, 1 bit: one-cycle pulse that zeroes the count for a new game.
- `clear_valid` input, 1 bit: one-cycle pulse meaning `clear_count` lines were just cleared.
- `clear_count` input, 3 bits: number of lines cleared, 0–7 accepted.
- `vblank` input, 1 bit: high while the VGA timing is in vertical blanking.
- `lines_total` output, `CNT_WIDTH` bits: registered binary count.
- `digit_chars` output, `NUM_DIGITS` x 8 bits: ASCII characters. Index 0 is the most significant digit.
- `busy` output, 1 bit: high while a conversion is running or waiting to be published.

## Operation
- States: IDLE, CONVERT, WAIT_VBLANK.
- Count update, registered:
  - `game_start` sets the count to 0. When it coincides with `clear_valid`, the clear is ignored.
  - Otherwise, `clear_valid` sets the count to min(count + `clear_count`, `MAX_COUNT`). The sum is computed at `CNT_WIDTH`+1 bits before the clamp.
- Events that start a conversion:
  - `game_start`.
  - `clear_valid` with `clear_count` ≠ 0.
  - `clear_valid` with `clear_count` = 0 is not an event. Nothing changes.
- On an event, from any state, the FSM goes to CONVERT:
  - The shift register is loaded with the new count value. This is the next-state value, not the old register.
  - The BCD accumulator (4·`NUM_DIGITS` bits) is cleared and the iteration counter is reset.
  - An event during CONVERT or WAIT_VBLANK aborts the current work and discards it. Only the newest count is ever published.
- CONVERT runs for exactly `CNT_WIDTH` cycles. Each cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - Then {BCD, shift} is shifted left by 1.
  - After the last iteration, the FSM goes to WAIT_VBLANK holding the result.
- WAIT_VBLANK:
  - In the first cycle that `vblank` is sampled high, the result is registered onto `digit_chars` and the FSM goes to IDLE.
  - If `vblank` is low, the FSM waits indefinitely.
- Character mapping:
  - Each digit d maps to 8'h30 + d.
  - Leading zeros map to space (8'h20). The least significant digit is always a numeral.
- `busy` = (state ≠ IDLE), decoded from registered state.

## Timing
- Reset values:
  - State IDLE.
  - `lines_total` = 0.
  - `digit_chars` = "   0" (20,20,20,30).
  - `busy` = 0.
  - Internal shift, BCD and iteration counter = 0.
- Reset asserted mid-conversion forces all of the above immediately. No publish occurs.
- Latency for an event in cycle 0:
  - `lines_total` is new in cycle 1.
  - CONVERT occupies cycles 1 to `CNT_WIDTH` (1–14).
  - WAIT_VBLANK is entered in cycle 15.
  - With `vblank` high in cycle 15, `digit_chars` changes in cycle 16. Minimum latency is `CNT_WIDTH`+2 cycles.
- `digit_chars` changes only on the clock edge that ends a cycle in which `vblank` was sampled high. It holds its value all other times.
- Back-to-back events restart the conversion. Continuous events every cycle starve publishing. This is accepted, because game events are frame-rate sparse.
- Saturation: at 9999, further clears keep the count at 9999. A conversion still runs and republishes "9999".

## Test plan
- Reset and idle: release `rst_l` and hold `vblank` high → `digit_chars` = "   0", `lines_total` = 0, `busy` = 0 indefinitely.
- Single clear: `clear_valid`=1 with `clear_count`=4 in cycle 0 and `vblank` held high → `lines_total` = 4 in cycle 1, `busy` high for cycles 1–15, `digit_chars` = "   4" in cycle 16.
- Vblank gating: count 37→40 (+3) with `vblank` low for 200 cycles after conversion → `digit_chars` stays "  37". On the `vblank` rise it becomes "  40" one cycle later.
- Restart: clear of 1 at cycle 0, then clear of 2 at cycle 5 (count 0→1→3) → "   1" is never published, "   3" appears in cycle 21 with `vblank` high.
- Saturation: count preloaded to 9998 via clears, then `clear_count`=4 → `lines_total` = 9999, `digit_chars` = "9999". A further clear of 1 leaves both unchanged.
- Priority: `game_start` and `clear_valid` (3) in the same cycle at count 120 → `lines_total` = 0, then `digit_chars` = "   0". A `clear_count`=0 pulse leaves `busy` low.
